// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared memory port: fetch (m0) vs load/store (m1).
// One outstanding transaction, registered slave request, streak limit and completion timeout.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_we,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  output logic                s_req,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_we,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_gnt,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata
);

  localparam int unsigned SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            TO_EN      = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;   // 1 = m1 owns the outstanding transaction
  logic [SW-1:0]         streak_q, streak_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  s_req_q, s_req_d;
  logic [ADDR_W-1:0]     s_addr_q, s_addr_d;
  logic                  s_we_q, s_we_d;
  logic [DATA_W-1:0]     s_wdata_q, s_wdata_d;
  logic [DATA_W/8-1:0]   s_wstrb_q, s_wstrb_d;
  logic                  rv0_q, rv0_d, rv1_q, rv1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic                  win0, win1, gnt0, gnt1;
  logic                  done, done_err;
  logic [DATA_W-1:0]     done_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      streak_q  <= '0;
      timer_q   <= '0;
      s_req_q   <= 1'b0;
      s_addr_q  <= '0;
      s_we_q    <= 1'b0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      timer_q   <= timer_d;
      s_req_q   <= s_req_d;
      s_addr_q  <= s_addr_d;
      s_we_q    <= s_we_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
      rv0_q     <= rv0_d;
      rv1_q     <= rv1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    streak_d  = streak_q;
    timer_d   = timer_q;
    s_req_d   = s_req_q;
    s_addr_d  = s_addr_q;
    s_we_d    = s_we_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rv0_d     = 1'b0;
    rv1_d     = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    win0      = 1'b0;
    win1      = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done      = 1'b0;
    done_err  = 1'b0;
    done_data = '0;

    unique case (state_q)
      IDLE: begin
        win1 = m1_req && !(m0_req && (streak_q == STREAK_MAX));
        win0 = m0_req && !win1;
        if (win1) begin
          gnt1      = 1'b1;
          owner_d   = 1'b1;
          s_addr_d  = m1_addr;
          s_we_d    = m1_we;
          s_wdata_d = m1_wdata;
          s_wstrb_d = m1_wstrb;
          s_req_d   = 1'b1;
          state_d   = ISSUE;
          // m1 only beats a waiting m0 below the limit, so +1 never overshoots
          streak_d  = m0_req ? streak_q + SW'(1) : '0;
        end else if (win0) begin
          gnt0      = 1'b1;
          owner_d   = 1'b0;
          s_addr_d  = m0_addr;
          s_we_d    = 1'b0;
          s_wdata_d = '0;
          s_wstrb_d = '0;
          s_req_d   = 1'b1;
          state_d   = ISSUE;
          streak_d  = '0;
        end
      end
      ISSUE: begin
        if (s_gnt) begin
          s_req_d = 1'b0;
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (s_rvalid) begin
          done      = 1'b1;
          done_data = s_rdata;
        end else if (TO_EN && (timer_q == TIMER_LAST)) begin
          done      = 1'b1;
          done_err  = 1'b1;
          done_data = '1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      state_d = IDLE;
      if (owner_q) begin
        rv1_d    = 1'b1;
        err1_d   = done_err;
        rdata1_d = done_data;
      end else begin
        rv0_d    = 1'b1;
        err0_d   = done_err;
        rdata0_d = done_data;
      end
    end
  end

  assign m0_gnt    = gnt0 & ~reset;
  assign m1_gnt    = gnt1 & ~reset;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign m0_err    = err0_q;
  assign m1_err    = err1_q;
  assign s_req     = s_req_q;
  assign s_addr    = s_addr_q;
  assign s_we      = s_we_q;
  assign s_wdata   = s_wdata_q;
  assign s_wstrb   = s_wstrb_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int          MS = 4;
  localparam int          TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_gnt, m0_rvalid, m0_err;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [3:0]    m1_wstrb;
  logic          s_req, s_we, s_gnt, s_rvalid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [3:0]    s_wstrb;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: at most one pending transaction, tracked by the cycle numbers of its events.
  bit          busy, accepted;
  int          owner, acc_cyc, streak, cyc, last_win;
  logic [31:0] p_addr, p_wdata;
  logic        p_we;
  logic [3:0]  p_wstrb;
  logic        e_rv0, e_rv1, e_err;
  logic [31:0] e_rd0, e_rd1;
  int          glog[$];

  task automatic model_reset();
    busy = 0; accepted = 0; streak = 0; owner = 0; acc_cyc = 0; last_win = -1;
    p_addr = '0; p_wdata = '0; p_we = 1'b0; p_wstrb = '0;
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_err = 1'b0; e_rd0 = '0; e_rd1 = '0;
  endtask

  // Inputs are set before the call; checks at the falling edge, then advance past the rising edge.
  task automatic step();
    int          win;
    bit          done;
    logic [31:0] dval;
    bit          derr;
    @(negedge clk);
    win = -1;
    if (!busy) begin
      if (m1_req && !(m0_req && streak == MS)) win = 1;
      else if (m0_req) win = 0;
    end
    chk("m0_gnt", m0_gnt, win == 0);
    chk("m1_gnt", m1_gnt, win == 1);
    chk("s_req", s_req, busy && !accepted);
    chk("s_addr", s_addr, p_addr);
    chk("s_we", s_we, p_we);
    chk("s_wdata", s_wdata, p_wdata);
    chk("s_wstrb", s_wstrb, p_wstrb);
    chk("m0_rvalid", m0_rvalid, e_rv0);
    chk("m1_rvalid", m1_rvalid, e_rv1);
    chk("m0_rdata", m0_rdata, e_rd0);
    chk("m1_rdata", m1_rdata, e_rd1);
    if (e_rv0) chk("m0_err", m0_err, e_err);
    if (e_rv1) chk("m1_err", m1_err, e_err);
    if (win >= 0) glog.push_back(win);
    last_win = win;

    e_rv0 = 1'b0; e_rv1 = 1'b0; e_err = 1'b0;
    done = 0; dval = '0; derr = 0;
    if (busy) begin
      if (!accepted) begin
        if (s_gnt) begin accepted = 1; acc_cyc = cyc; end
      end else if (s_rvalid) begin
        done = 1; dval = s_rdata;
      end else if (cyc - acc_cyc == TO) begin
        done = 1; dval = '1; derr = 1;
      end
    end
    if (done) begin
      busy = 0; e_err = derr;
      if (owner == 1) begin e_rv1 = 1'b1; e_rd1 = dval; end
      else begin e_rv0 = 1'b1; e_rd0 = dval; end
    end
    if (win == 0) begin
      streak = 0; owner = 0; busy = 1; accepted = 0;
      p_addr = m0_addr; p_we = 1'b0; p_wdata = '0; p_wstrb = '0;
    end else if (win == 1) begin
      streak = m0_req ? ((streak < MS) ? streak + 1 : MS) : 0;
      owner = 1; busy = 1; accepted = 0;
      p_addr = m1_addr; p_we = m1_we; p_wdata = m1_wdata; p_wstrb = m1_wstrb;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {m0_gnt, m1_gnt}, 2'b00);
    chk({tag, "_rvalid"}, {m0_rvalid, m1_rvalid}, 2'b00);
    chk({tag, "_err"}, {m0_err, m1_err}, 2'b00);
    chk({tag, "_rdata"}, {m0_rdata, m1_rdata}, 64'h0);
    chk({tag, "_sreq"}, {s_req, s_we, s_wstrb}, 6'h0);
    chk({tag, "_spay"}, {s_addr, s_wdata}, 64'h0);
  endtask

  initial begin
    int n;
    bit quiet;
    reset = 1'b1;
    m0_req = 0; m0_addr = '0; m1_req = 0; m1_addr = '0; m1_we = 0; m1_wdata = '0; m1_wstrb = '0;
    s_gnt = 0; s_rvalid = 0; s_rdata = '0;
    cyc = 0;
    model_reset();
    #1;
    chk_all_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    step();

    // m0 read, slave grants immediately and completes the next cycle
    m0_req = 1; m0_addr = 32'h100;
    step();
    m0_req = 0; s_gnt = 1;
    step();
    s_gnt = 0; s_rvalid = 1; s_rdata = 32'h12345678;
    step();
    s_rvalid = 0; s_rdata = '0;
    step();
    chk("rd_m0", m0_rdata, 32'h12345678);
    step();

    // m1 write with the slave stalling its grant for three cycles
    m1_req = 1; m1_we = 1; m1_addr = 32'h2000; m1_wdata = 32'hAABBCCDD; m1_wstrb = 4'h3;
    step();
    m1_req = 0;
    repeat (3) step();
    s_gnt = 1;
    step();
    s_gnt = 0; s_rvalid = 1; s_rdata = 32'h0BAD0BAD;
    step();
    s_rvalid = 0;
    chk("wr_err", m1_err, 1'b0);
    step();
    step();

    // both masters saturating the bus: streak limit lets m0 in every fifth grant
    glog.delete();
    m0_req = 1; m1_req = 1; m1_we = 0; s_gnt = 1; s_rvalid = 1;
    repeat (32) begin
      if (last_win == 0) m0_addr = $urandom;
      if (last_win == 1) m1_addr = $urandom;
      s_rdata = $urandom;
      step();
    end
    chk("order_n", glog.size() >= 10, 1'b1);
    for (int i = 0; i < 10 && i < glog.size(); i++)
      chk("order", glog[i], (i % 5 == 4) ? 0 : 1);
    m0_req = 0; m1_req = 0;
    repeat (4) step();

    // slave never completes: timeout 9 cycles after the slave grant, then normal service resumes
    s_gnt = 0; s_rvalid = 0;
    m1_req = 1; m1_we = 0; m1_addr = 32'h3000;
    step();
    m1_req = 0; s_gnt = 1;
    step();
    s_gnt = 0;
    n = 1;
    while (!m1_rvalid && n < 20) begin
      step();
      n++;
    end
    chk("to_lat", n, 9);
    chk("to_err", m1_err, 1'b1);
    chk("to_rdata", m1_rdata, 32'hFFFFFFFF);
    step();
    m0_req = 1; m0_addr = 32'h440; s_gnt = 1;
    step();
    m0_req = 0;
    step();
    s_gnt = 0; s_rvalid = 1; s_rdata = 32'hC0FFEE01;
    step();
    s_rvalid = 0;
    chk("after_to", m0_rdata, 32'hC0FFEE01);
    step();

    // reset while waiting for completion; late s_rvalid must be ignored
    m0_req = 1; m0_addr = 32'h500;
    step();
    m0_req = 0; s_gnt = 1;
    step();
    s_gnt = 0;
    repeat (2) step();
    m0_req = 1; m1_req = 1;
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    m0_req = 0; m1_req = 0;
    model_reset();
    @(negedge clk) reset = 1'b0;
    s_rvalid = 1; s_rdata = 32'hDEADBEEF;
    @(posedge clk); #1; cyc++;
    s_rvalid = 0;
    m0_req = 1; m0_addr = 32'h600;
    step();
    chk("post_rst_gnt", last_win, 0);
    m0_req = 0; s_gnt = 1;
    step();
    s_gnt = 0; s_rvalid = 1; s_rdata = 32'h600D600D;
    step();
    s_rvalid = 0;
    repeat (2) step();

    // randomized traffic with periodic quiet-slave windows to exercise the timeout
    quiet = 0;
    for (int k = 0; k < 2500; k++) begin
      if (k % 250 == 0) quiet = 0;
      if (k % 250 == 180) quiet = 1;
      if (last_win == 0 || !m0_req) begin
        m0_req = ($urandom % 2 == 0);
        m0_addr = $urandom;
      end else if ($urandom % 32 == 0) begin
        m0_req = 0;
      end
      if (last_win == 1 || !m1_req) begin
        m1_req = ($urandom % 2 == 0);
        m1_addr = $urandom; m1_we = $urandom; m1_wdata = $urandom; m1_wstrb = $urandom;
      end else if ($urandom % 32 == 0) begin
        m1_req = 0;
      end
      s_gnt = ($urandom % 3 == 0);
      s_rvalid = quiet ? 1'b0 : ($urandom % 4 == 0);
      s_rdata = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
